// File: rtl/mem_copy_dma_if.sv
// ============================================================================
// Module   : mem_copy_dma_if
// Purpose  : Native valid/ready memory bus used by the block-copy initiator.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_copy_dma_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_copy_dma.sv
// ============================================================================
// Module   : mem_copy_dma
// Purpose  : Bus initiator copying a block of 32-bit words, one read then one
//            write per word, with a per-transaction stall watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_copy_dma #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_done_o,
  mem_copy_dma_if.master   mem
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RGAP = 3'd2,
    S_WR   = 3'd3,
    S_WGAP = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      data_q, data_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d;
  logic             valid_q, valid_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;

  logic fire;
  logic stall;
  logic expired;

  assign fire    = valid_q && mem.mem_ready;
  assign stall   = valid_q && !mem.mem_ready;
  assign expired = stall && (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    wd_d    = stall ? wd_q + 1'b1 : '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;

    case (state_q)
      S_IDLE: begin
        // busy is still high during the done cycle, so a start there is dropped
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (start_i) begin
          busy_d  = 1'b1;
          err_d   = 1'b0;
          wcnt_d  = '0;
          src_d   = src_addr_i & ~32'd3;
          dst_d   = dst_addr_i & ~32'd3;
          rem_d   = len_i;
          if (len_i == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RD;
            valid_d = 1'b1;
            addr_d  = src_addr_i & ~32'd3;
            wstrb_d = 4'b0000;
          end
        end
      end
      S_RD: begin
        if (fire) begin
          data_d  = mem.mem_rdata;
          src_d   = src_q + 32'd4;
          valid_d = 1'b0;
          state_d = S_RGAP;
        end
      end
      S_RGAP: begin
        valid_d = 1'b1;
        addr_d  = dst_q;
        wdata_d = data_q;
        wstrb_d = 4'b1111;
        state_d = S_WR;
      end
      S_WR: begin
        if (fire) begin
          dst_d   = dst_q + 32'd4;
          wcnt_d  = wcnt_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          valid_d = 1'b0;
          wstrb_d = 4'b0000;
          state_d = (rem_q == LEN_W'(1)) ? S_FIN : S_WGAP;
        end
      end
      S_WGAP: begin
        valid_d = 1'b1;
        addr_d  = src_q;
        wstrb_d = 4'b0000;
        state_d = S_RD;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // watchdog abort overrides any pending transaction in RD or WR
    if (expired && (state_q == S_RD || state_q == S_WR)) begin
      valid_d = 1'b0;
      wstrb_d = 4'b0000;
      err_d   = 1'b1;
      state_d = S_FIN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign words_done_o  = wcnt_q;
  assign mem.mem_valid = valid_q;
  assign mem.mem_instr = 1'b0;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
// ============================================================================
// Module   : tb_mem_copy_dma
// Purpose  : Self-checking bench: memory responder plus a word-copy model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_copy_dma;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 256;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      src, dst;
  logic [LEN_W-1:0] len;
  logic             busy, done, err;
  logic [LEN_W-1:0] words_done;

  mem_copy_dma_if bus ();

  mem_copy_dma #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .src_addr_i   (src),
    .dst_addr_i   (dst),
    .len_i        (len),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .words_done_o (words_done),
    .mem          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // bus-side memory and the model's own copy of memory
  logic [31:0] mem  [bit [31:0]];
  logic [31:0] mmem [bit [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : dflt(a);
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] obs_rd[$];
  int          exp_words;
  logic        exp_err;
  bit          blk_en = 1'b0;
  logic [31:0] blk_addr = '0;
  int          mode_wait = 0;
  int          valid_cycles = 0;
  int          last_stall = 0;

  // Model: sequential word copy; an access to the blocked address aborts.
  task automatic build_expect(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] a, b, v;
    a = s & ~32'd3;
    b = d & ~32'd3;
    exp_q.delete();
    exp_words = 0;
    exp_err   = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (blk_en && a == blk_addr) begin exp_err = 1'b1; break; end
      v = mrd(a);
      exp_q.push_back('{1'b0, a, v});
      if (blk_en && b == blk_addr) begin exp_err = 1'b1; break; end
      exp_q.push_back('{1'b1, b, v});
      mmem[b] = v;
      exp_words++;
      a = a + 32'd4;
      b = b + 32'd4;
    end
  endtask

  // Responder and per-cycle compare process
  bit          pend = 1'b0;
  bit          gap_chk = 1'b0;
  int          wcnt = 0;
  int          stall = 0;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;

  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0; gap_chk = 1'b0; stall = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
    end else begin
      if (gap_chk) begin
        chk("valid_gap", {31'b0, bus.mem_valid}, 32'd0);
        gap_chk = 1'b0;
      end
      if (bus.mem_valid) begin
        valid_cycles++;
        chk("instr_zero", {31'b0, bus.mem_instr}, 32'd0);
        chk("addr_align", {30'b0, bus.mem_addr[1:0]}, 32'd0);
        chk("busy_with_valid", {31'b0, busy}, 32'd1);
        if (!pend) begin
          pend = 1'b1; stall = 0;
          p_addr = bus.mem_addr; p_wdata = bus.mem_wdata; p_wstrb = bus.mem_wstrb;
          wcnt = (mode_wait > 0) ? int'($urandom_range(0, mode_wait)) : 0;
        end else begin
          chk("hold_addr", bus.mem_addr, p_addr);
          chk("hold_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, p_wstrb});
          if (p_wstrb == 4'hF) chk("hold_wdata", bus.mem_wdata, p_wdata);
        end
        if (blk_en && bus.mem_addr == blk_addr) begin
          bus.mem_ready = 1'b0; stall++;
        end else if (wcnt == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : dflt(bus.mem_addr);
          pend = 1'b0; gap_chk = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_txn", bus.mem_addr, 32'hXXXX_XXXX);
          end else begin
            txn_t e;
            e = exp_q.pop_front();
            chk("txn_wstrb", {28'b0, bus.mem_wstrb}, e.we ? 32'hF : 32'h0);
            chk("txn_addr", bus.mem_addr, e.addr);
            if (e.we) chk("txn_wdata", bus.mem_wdata, e.data);
          end
          if (bus.mem_wstrb == 4'hF) mem[bus.mem_addr] = bus.mem_wdata;
          else obs_rd.push_back(bus.mem_addr);
        end else begin
          wcnt--; bus.mem_ready = 1'b0; stall++;
        end
      end else begin
        if (pend) begin last_stall = stall; pend = 1'b0; end
        bus.mem_ready = (mode_wait > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a] = v;
    mmem[a] = v;
  endtask

  // Start a copy and wait for done; dcyc = cycle index of done (start cycle = 0)
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          output int dcyc);
    build_expect(s, d, n);
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = LEN_W'(n);
    @(negedge clk);
    start = 1'b0;
    dcyc = 0;
    for (int c = 1; c <= 4000; c++) begin
      if (done) begin dcyc = c; break; end
      if (!busy) chk("busy_hold", {31'b0, busy}, 32'd1);
      @(negedge clk);
    end
    if (dcyc == 0) chk("done_timeout", 32'd0, 32'd1);
    chk("words_done", {24'b0, words_done}, exp_words);
    chk("err_flag", {31'b0, err}, {31'b0, exp_err});
    chk("model_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    chk("done_pulse_width", {31'b0, done}, 32'd0);
    chk("busy_after_done", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int dc;
    int found;
    reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_words", {24'b0, words_done}, 32'd0);
    chk("rst_valid", {31'b0, bus.mem_valid}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: basic copy of four words, zero-wait responder
    for (int i = 0; i < 4; i++) preload(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    obs_rd.delete();
    run_copy(32'h100, 32'h200, 4, dc);
    chk("t1_latency", {31'b0, (dc >= 17 && dc <= 18)}, 32'd1);
    chk("t1_mem200", mem[32'h200], 32'hA000_0000);
    chk("t1_mem204", mem[32'h204], 32'hA000_0001);
    chk("t1_mem208", mem[32'h208], 32'hA000_0002);
    chk("t1_mem20C", mem[32'h20C], 32'hA000_0003);
    chk("t1_rd3", obs_rd[3], 32'h10C);

    // 2: zero-length copy
    valid_cycles = 0;
    run_copy(32'h100, 32'h200, 0, dc);
    chk("t2_latency", dc, 32'd2);
    chk("t2_no_valid", valid_cycles, 32'd0);

    // 3: random wait states
    for (int i = 0; i < 16; i++) preload(32'h1000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i * 7));
    mode_wait = 5;
    run_copy(32'h1000, 32'h2000, 16, dc);
    mode_wait = 0;
    for (int i = 0; i < 16; i += 5)
      chk("t3_mem", mem[32'h2000 + 32'(4 * i)], mrd(32'h2000 + 32'(4 * i)));
    chk("t3_mem_last", mem[32'h203C], 32'hC0DE_0069);

    // 4: write never acknowledged -> watchdog abort
    blk_en = 1'b1; blk_addr = 32'h400;
    run_copy(32'h100, 32'h400, 3, dc);
    chk("t4_stall_len", last_stall, TIMEOUT);
    chk("t4_err_held", {31'b0, err}, 32'd1);
    blk_en = 1'b0;
    run_copy(32'h100, 32'h600, 1, dc);
    chk("t4_mem600", mem[32'h600], 32'hA000_0000);

    // 5: address wrap and unaligned source
    preload(32'hFFFF_FFF8, 32'h1234_5678);
    preload(32'hFFFF_FFFC, 32'h9ABC_DEF0);
    preload(32'h0000_0000, 32'h0F0F_0F0F);
    obs_rd.delete();
    run_copy(32'hFFFF_FFF8, 32'h10, 3, dc);
    chk("t5_nrd", obs_rd.size(), 32'd3);
    chk("t5_rd0", obs_rd[0], 32'hFFFF_FFF8);
    chk("t5_rd1", obs_rd[1], 32'hFFFF_FFFC);
    chk("t5_rd2", obs_rd[2], 32'h0000_0000);
    chk("t5_mem18", mem[32'h18], 32'h0F0F_0F0F);
    obs_rd.delete();
    run_copy(32'h103, 32'h303, 1, dc);
    chk("t5_unaligned_rd", obs_rd[0], 32'h100);
    chk("t5_mem300", mem[32'h300], 32'hA000_0000);

    // 6: reset during the second write, then start while busy
    blk_en = 1'b1; blk_addr = 32'h504;
    build_expect(32'h100, 32'h500, 4);
    @(negedge clk);
    start = 1'b1; src = 32'h100; dst = 32'h500; len = 4;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.mem_valid && bus.mem_addr == 32'h504 && bus.mem_wstrb == 4'hF) begin
        found = 1; break;
      end
      @(negedge clk);
    end
    chk("t6_second_write_seen", found, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", {31'b0, bus.mem_valid}, 32'd0);
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    chk("t6_rst_words", {24'b0, words_done}, 32'd0);
    chk("t6_rst_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
    chk("t6_rst_addr", bus.mem_addr, 32'd0);
    chk("t6_model_drained", exp_q.size(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    blk_en = 1'b0;
    found = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) found = 1;
    end
    chk("t6_no_done_after_reset", found, 32'd0);
    fork
      run_copy(32'h100, 32'h700, 2, dc);
      begin
        repeat (4) @(negedge clk);
        start = 1'b1; src = 32'h900; dst = 32'hA00; len = 7;
        @(negedge clk);
        start = 1'b0;
      end
    join
    chk("t6_words_original", {24'b0, words_done}, 32'd2);
    chk("t6_mem704", mem[32'h704], 32'hA000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

`default_nettype wire
